// File: rtl/aes_job_scheduler.sv
// Round-robin front end that shares one AES-128 core among NREQ requesters,
// one job in flight, with a RUN-cycle timeout that aborts a hung core.
module aes_job_scheduler #(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int TIMEOUT = 32,
   parameter int CNTW    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*128-1:0]   req_pt,
   input  logic [NREQ*128-1:0]   req_key,
   output logic                  core_start,
   output logic                  core_abort,
   output logic [127:0]          core_pt,
   output logic [127:0]          core_key,
   input  logic                  core_done,
   input  logic [127:0]          core_ct,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [127:0]          rsp_ct,
   output logic                  rsp_err,
   output logic                  busy,
   output logic [CNTW-1:0]       jobs_done,
   output logic [CNTW-1:0]       jobs_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

   state_t          state;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  id_q;
   logic [CW-1:0]   cnt;
   logic [127:0]    pt_q, key_q, ct_q;
   logic            err_q;

   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_id;
   logic            gnt_any;
   logic            timeout_hit;

   // Scan from rr_ptr upward with wraparound; first valid requester wins.
   always_comb begin
      int j;
      logic [IDW-1:0] jx;
      gnt     = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      j       = 0;
      jx      = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         jx = IDW'(j);
         if (!gnt_any && req_valid[jx]) begin
            gnt_any  = 1'b1;
            gnt[jx]  = 1'b1;
            gnt_id   = jx;
         end
      end
   end

   // core_done takes priority over an expiring timeout in the same cycle.
   assign timeout_hit = (state == RUN) && !core_done && (cnt == CW'(TIMEOUT - 1));

   assign req_ready  = (state == IDLE) ? gnt : '0;
   assign core_start = (state == LOAD);
   assign core_abort = timeout_hit;
   assign rsp_valid  = (state == RESP);
   assign busy       = (state != IDLE);
   assign core_pt    = pt_q;
   assign core_key   = key_q;
   assign rsp_id     = id_q;
   assign rsp_ct     = ct_q;
   assign rsp_err    = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         id_q      <= '0;
         cnt       <= '0;
         pt_q      <= '0;
         key_q     <= '0;
         ct_q      <= '0;
         err_q     <= 1'b0;
         jobs_done <= '0;
         jobs_err  <= '0;
      end else begin
         case (state)
            IDLE: if (gnt_any) begin
               pt_q  <= req_pt[int'(gnt_id)*128 +: 128];
               key_q <= req_key[int'(gnt_id)*128 +: 128];
               id_q  <= gnt_id;
               state <= LOAD;
            end
            LOAD: begin
               cnt   <= '0;
               state <= RUN;
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (core_done) begin
                  ct_q  <= core_ct;
                  err_q <= 1'b0;
                  state <= RESP;
               end else if (timeout_hit) begin
                  ct_q  <= '0;
                  err_q <= 1'b1;
                  state <= RESP;
               end
            end
            RESP: if (rsp_ready) begin
               rr_ptr    <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
               jobs_done <= jobs_done + 1'b1;
               if (err_q) jobs_err <= jobs_err + 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed bench for aes_job_scheduler with a simple delay-programmable core model.
module tb_aes_job_scheduler;

   localparam int NREQ = 4, IDW = 2, TO = 16, CNTW = 16;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT2 = 128'hdeadbeef00000000cafef00d12345678;
   localparam logic [127:0] CT3 = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] CT4 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*128-1:0]  req_pt;
   logic [NREQ*128-1:0]  req_key;
   logic                 core_start, core_abort;
   logic [127:0]         core_pt, core_key;
   logic                 core_done = 1'b0;
   logic [127:0]         core_ct;
   logic                 rsp_valid, rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic [127:0]         rsp_ct;
   logic                 rsp_err, busy;
   logic [CNTW-1:0]      jobs_done, jobs_err;

   int checks = 0;
   int errors = 0;
   int dly = 0;
   int cd = 0;
   logic [127:0] model_ct = '0;

   aes_job_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TO), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_pt(req_pt), .req_key(req_key),
      .core_start(core_start), .core_abort(core_abort), .core_pt(core_pt), .core_key(core_key),
      .core_done(core_done), .core_ct(core_ct),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_ct(rsp_ct),
      .rsp_err(rsp_err), .busy(busy), .jobs_done(jobs_done), .jobs_err(jobs_err)
   );

   always #5 clk = ~clk;
   assign core_ct = model_ct;

   // Core model: done pulses dly cycles after the start cycle; dly=0 never finishes.
   always @(negedge clk) begin
      core_done = 1'b0;
      if (reset) cd = 0;
      else if (core_start) cd = dly;
      else if (cd > 0) begin
         cd = cd - 1;
         if (cd == 0) core_done = 1'b1;
      end
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_pt = '0; req_key = '0; dly = 0;
      tick; tick;
      checks++;
      if ({core_start, core_abort, rsp_valid, busy, req_ready, rsp_err, rsp_id} !== '0) begin
         errors++; $display("FAIL reset_ctrl got %h want 0", {core_start, core_abort, rsp_valid, busy, req_ready, rsp_err, rsp_id});
      end
      checks++;
      if ({core_pt, core_key, rsp_ct} !== '0) begin
         errors++; $display("FAIL reset_data got %h want 0", {core_pt, core_key, rsp_ct});
      end
      checks++;
      if ({jobs_done, jobs_err} !== '0) begin
         errors++; $display("FAIL reset_stats got %h want 0", {jobs_done, jobs_err});
      end
      reset = 1'b0;
      tick;
      checks++;
      if ({busy, req_ready} !== '0) begin
         errors++; $display("FAIL idle_no_req got %h want 0", {busy, req_ready});
      end
   endtask

   task automatic test_nist;
      int n;
      req_pt[2*128 +: 128] = PT; req_key[2*128 +: 128] = KEY;
      model_ct = CT; dly = 11; req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL nist_grant got %b want 0100", req_ready);
      end
      tick; req_valid = '0;
      checks++;
      if ({core_start, core_pt, core_key} !== {1'b1, PT, KEY}) begin
         errors++; $display("FAIL nist_load got start=%b pt=%h key=%h", core_start, core_pt, core_key);
      end
      n = 0;
      while (!rsp_valid && n < 40) begin tick; n++; end
      checks++;
      if (n != 12) begin
         errors++; $display("FAIL nist_latency got %0d want 12", n);
      end
      checks++;
      if ({rsp_id, rsp_ct, rsp_err} !== {2'd2, CT, 1'b0}) begin
         errors++; $display("FAIL nist_rsp got id=%0d ct=%h err=%b want id=2 ct=%h err=0", rsp_id, rsp_ct, rsp_err, CT);
      end
      rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
      checks++;
      if ({rsp_valid, jobs_done} !== {1'b0, 16'd1}) begin
         errors++; $display("FAIL nist_hs got valid=%b done=%0d want 0/1", rsp_valid, jobs_done);
      end
   endtask

   task automatic test_reset_mid_run;
      int n;
      logic seen;
      req_pt[3*128 +: 128] = CT2; dly = 11; req_valid = 4'b1000;
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++; $display("FAIL midrst_grant got %b want 1000", req_ready);
      end
      tick; req_valid = '0;
      tick; tick; tick;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL midrst_busy got %b want 1", busy);
      end
      reset = 1'b1; #1;
      checks++;
      if ({core_start, core_abort, rsp_valid, busy, req_ready, rsp_err, rsp_id, jobs_done, jobs_err} !== '0) begin
         errors++; $display("FAIL midrst_outs got %h want 0", {core_start, core_abort, rsp_valid, busy, req_ready, rsp_err, rsp_id, jobs_done, jobs_err});
      end
      checks++;
      if ({core_pt, core_key, rsp_ct} !== '0) begin
         errors++; $display("FAIL midrst_data got %h want 0", {core_pt, core_key, rsp_ct});
      end
      tick; reset = 1'b0;
      seen = 1'b0;
      for (n = 0; n < 20; n++) begin tick; seen |= rsp_valid | busy; end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL midrst_norsp got %b want 0", seen);
      end
      req_valid = 4'hf; #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL midrst_rr got %b want 0001", req_ready);
      end
      req_valid = '0; #1;
   endtask

   task automatic test_round_robin;
      int n, oh_bad;
      logic [3:0] exp;
      oh_bad = 0; dly = 3; model_ct = CT2; rsp_ready = 1'b1; req_valid = 4'hf;
      #1;
      for (int k = 0; k < 6; k++) begin
         n = 0;
         while (req_ready == '0 && n < 30) begin
            tick; n++;
            if (!$onehot0(req_ready)) oh_bad++;
         end
         exp = 4'b0001 << (k % 4);
         checks++;
         if (req_ready !== exp) begin
            errors++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, exp);
         end
         tick;
      end
      req_valid = '0;
      n = 0;
      while (busy && n < 30) begin tick; n++; end
      rsp_ready = 1'b0;
      checks++;
      if (oh_bad != 0) begin
         errors++; $display("FAIL rr_onehot got %0d bad cycles want 0", oh_bad);
      end
      checks++;
      if (jobs_done !== 16'd6) begin
         errors++; $display("FAIL rr_count got %0d want 6", jobs_done);
      end
   endtask

   task automatic test_back_pressure;
      int n;
      dly = 5; model_ct = CT3; rsp_ready = 1'b0; req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL bp_grant got %b want 0001", req_ready);
      end
      tick; req_valid = '0;
      n = 0;
      while (!rsp_valid && n < 30) begin tick; n++; end
      req_valid = 4'b0010; #1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ({rsp_valid, rsp_id, rsp_ct, rsp_err, req_ready, core_start, jobs_done} !==
             {1'b1, 2'd0, CT3, 1'b0, 4'b0000, 1'b0, 16'd6}) begin
            errors++; $display("FAIL bp_hold%0d got v=%b id=%0d ct=%h err=%b rdy=%b st=%b done=%0d", k,
                               rsp_valid, rsp_id, rsp_ct, rsp_err, req_ready, core_start, jobs_done);
         end
         tick;
      end
      req_valid = '0; rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
      checks++;
      if ({rsp_valid, jobs_done} !== {1'b0, 16'd7}) begin
         errors++; $display("FAIL bp_hs got valid=%b done=%0d want 0/7", rsp_valid, jobs_done);
      end
   endtask

   task automatic test_timeout;
      int n;
      dly = 0; model_ct = CT; req_valid = 4'b0010;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++; $display("FAIL to_grant got %b want 0010", req_ready);
      end
      tick; req_valid = '0;
      n = 0;
      while (!core_abort && n < 30) begin tick; n++; end
      checks++;
      if (n != 16) begin
         errors++; $display("FAIL to_abort_cycle got %0d want 16", n);
      end
      tick;
      checks++;
      if ({core_abort, rsp_valid, rsp_err, rsp_ct, rsp_id} !== {1'b0, 1'b1, 1'b1, 128'd0, 2'd1}) begin
         errors++; $display("FAIL to_rsp got ab=%b v=%b err=%b ct=%h id=%0d", core_abort, rsp_valid, rsp_err, rsp_ct, rsp_id);
      end
      rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
      checks++;
      if ({jobs_err, jobs_done} !== {16'd1, 16'd8}) begin
         errors++; $display("FAIL to_stats got err=%0d done=%0d want 1/8", jobs_err, jobs_done);
      end
   endtask

   task automatic test_done_at_timeout;
      logic ab;
      dly = 16; model_ct = CT4; req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL race_grant got %b want 0100", req_ready);
      end
      tick; req_valid = '0;
      ab = 1'b0;
      for (int k = 0; k < 16; k++) begin tick; ab |= core_abort; end
      checks++;
      if ({core_done, ab} !== 2'b10) begin
         errors++; $display("FAIL race_abort got done=%b abort=%b want 1/0", core_done, ab);
      end
      tick;
      checks++;
      if ({rsp_valid, rsp_err, rsp_ct, rsp_id} !== {1'b1, 1'b0, CT4, 2'd2}) begin
         errors++; $display("FAIL race_rsp got v=%b err=%b ct=%h id=%0d", rsp_valid, rsp_err, rsp_ct, rsp_id);
      end
      rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
      checks++;
      if ({jobs_err, jobs_done} !== {16'd1, 16'd9}) begin
         errors++; $display("FAIL race_stats got err=%0d done=%0d want 1/9", jobs_err, jobs_done);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_nist;
      test_reset_mid_run;
      test_round_robin;
      test_back_pressure;
      test_timeout;
      test_done_at_timeout;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
